// File: rtl/ll_control.sv
// Lunar lander control: divides the system clock into simulation steps, pulses
// the memory write enable once per step and latches the touchdown outcome.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FLY     | simulation running, prescaler counting, wen pulses each step
// LANDED  | touchdown below crash limits, simulation frozen until reset
// CRASHED | touchdown too fast or under excess thrust, frozen until reset
module ll_control #(
    parameter int          TICK_DIV   = 25,
    parameter logic [15:0] CRASH_VEL  = 16'h0030,
    parameter logic [15:0] THRUST_MAX = 16'h0005
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] alt,
    input  logic [15:0] vel,
    input  logic [15:0] thrust,
    input  logic [15:0] alt_n,
    output logic        wen,
    output logic        land,
    output logic        crash,
    output logic [7:0]  step
);

    typedef enum logic [1:0] {
        FLY     = 2'd0,
        LANDED  = 2'd1,
        CRASHED = 2'd2
    } state_t;

    localparam logic [7:0] STEP_LAST = 8'(TICK_DIV - 1);

    // Ten's complement of a 4-digit BCD word: per-digit 9's complement, then +1 in BCD.
    function automatic logic [15:0] bcd_tens_comp(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        logic [4:0]  sum;
        r     = '0;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sum = {1'b0, 4'd9 - v[4*i +: 4]} + {4'b0000, carry};
            if (sum > 5'd9) begin
                r[4*i +: 4] = 4'(sum - 5'd10);
                carry       = 1'b1;
            end else begin
                r[4*i +: 4] = sum[3:0];
                carry       = 1'b0;
            end
        end
        return r;
    endfunction

    // a >= b for 4-digit BCD, most significant differing digit decides.
    function automatic logic bcd_ge(input logic [15:0] a, input logic [15:0] b);
        logic ge;
        logic decided;
        ge      = 1'b1;
        decided = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                ge      = a[4*i +: 4] > b[4*i +: 4];
                decided = 1'b1;
            end
        end
        return ge;
    endfunction

    state_t      state, state_nxt;
    logic [15:0] speed;
    logic        crash_cond;
    logic        touchdown;

    // Current altitude is not needed: the ALU's clamped next altitude decides touchdown.
    logic unused_alt;
    assign unused_alt = ^alt;

    always_comb begin
        speed = 16'h0000;
        if (vel[15:12] >= 4'd5) begin
            speed = bcd_tens_comp(vel);
        end
    end

    assign crash_cond = bcd_ge(speed, CRASH_VEL) || !bcd_ge(THRUST_MAX, thrust);
    assign touchdown  = wen && (alt_n == 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FLY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FLY: begin
                if (touchdown) begin
                    state_nxt = crash_cond ? CRASHED : LANDED;
                end
            end
            LANDED:  state_nxt = LANDED;
            CRASHED: state_nxt = CRASHED;
            default: state_nxt = FLY;
        endcase
    end

    always_comb begin
        wen   = (state == FLY) && (step == STEP_LAST);
        land  = (state == LANDED);
        crash = (state == CRASHED);
    end

    // Prescaler runs only while flying; the touchdown edge also wraps it to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= 8'd0;
        end else if (state != FLY) begin
            step <= 8'd0;
        end else if (step == STEP_LAST) begin
            step <= 8'd0;
        end else begin
            step <= step + 8'd1;
        end
    end

endmodule

// File: doc/ll_control.md
# ll_control

Control unit for the lunar lander. Sits between `ll_alu` and `ll_memory`. It divides the 100 Hz system clock into simulation steps and drives the memory write enable `wen` once per step. It also detects touchdown from the ALU's next-state altitude and latches the landing outcome: safe landing or crash. Once the lander is down it freezes the simulation until reset.

## Interface
Parameters:
- `TICK_DIV`, default 25: clock cycles per simulation step (100 Hz / 25 = 4 steps/s); legal range 2..255.
- `CRASH_VEL`, default 16'h0030: BCD downward speed at or above which touchdown is a crash.
- `THRUST_MAX`, default 16'h0005: BCD thrust above which touchdown is a crash.

Ports:
- `clk`, input, 1: system clock (`hz100` at top).
- `rst_n`, input, 1: asynchronous, active-low reset.
- `alt`, input, 16: current altitude from `ll_memory`, 4-digit BCD.
- `vel`, input, 16: current velocity from `ll_memory`, 4-digit BCD ten's complement; negative means downward.
- `thrust`, input, 16: current thrust from `ll_memory`, BCD, 0000..0009.
- `alt_n`, input, 16: next altitude from `ll_alu`. It is already clamped to 0 when the raw sum went negative.
- `wen`, output, 1: write enable to `ll_memory`; one-cycle pulse per step while flying.
- `land`, output, 1: level; safe landing latched.
- `crash`, output, 1: level; crash latched.
- `step`, output, 8: binary prescaler count, exported for debug and display.

## Operation
- State machine, 2-bit state register: `FLY` (reset state), `LANDED`, `CRASHED`.
- Prescaler:
  - In `FLY`, `step` counts 0..`TICK_DIV`-1 and wraps to 0.
  - In `LANDED` and `CRASHED`, `step` holds at 0.
- `wen` is a combinational decode: `wen` = (state==`FLY`) && (`step`==`TICK_DIV`-1). It is never high outside `FLY`.
- Touchdown condition, evaluated only in a `wen` cycle: `alt_n`==16'h0000.
  - Raw negative results are clamped to 0 by the ALU, so this single compare covers both exact and overshoot touchdown.
- Downward speed, computed from `vel` (the pre-step value):
  - If `vel` >= 16'h5000 (negative), speed = BCD ten's complement of `vel`: 9's complement per digit, then +1 BCD.
  - Otherwise speed = 0; upward or zero velocity cannot crash.
- Crash on touchdown if speed >= `CRASH_VEL` (BCD compare, digit-wise, MSD first) OR `thrust` > `THRUST_MAX`. Otherwise the outcome is a safe landing.
- Transitions, all on the rising clk edge:
  - `FLY` → `CRASHED` when touchdown and the crash condition holds.
  - `FLY` → `LANDED` when touchdown and no crash.
  - `LANDED` and `CRASHED` are absorbing until `rst_n` is asserted.
- The touchdown `wen` pulse is still issued, so memory captures `alt_n`=0 and the ALU's zeroed velocity on the same edge the state changes.
- `land` = state==`LANDED`; `crash` = state==`CRASHED`. Both are registered-state decodes, so they are glitch-free and never high together.
- If `alt` is already 0 at reset (parameter misuse), the first `wen` cycle performs the touchdown evaluation normally.

## Timing
- Reset values: state=`FLY`, `step`=0, `wen`=0, `land`=0, `crash`=0.
- Reset applies immediately on `rst_n` falling, independent of `clk`, and is released synchronously on the first edge after `rst_n` rises.
- Reset mid-step: the partial count is discarded; the next `wen` comes `TICK_DIV`-1 edges after release.
- First `wen`: `step` reaches `TICK_DIV`-1 after `TICK_DIV`-1 rising edges following release. `wen` is high for exactly that one cycle.
- Steady state: `wen` period = `TICK_DIV` cycles, duty = 1 cycle.
- Outcome latency: `land`/`crash` rise on the same edge that memory captures the touchdown values, i.e. 0 cycles after the `wen` edge. Afterwards `wen` stays 0 indefinitely.
- Inputs (`alt_n`, `vel`, `thrust`) are sampled only at the `wen` edge. Changes between steps have no effect.

## Test plan
- Step cadence with `TICK_DIV`=25, `alt_n` held at 16'h4500:
  - `wen` pulses at cycles 24, 49, 74.
  - `step` wraps 24→0.
  - `land`/`crash` remain 0.
- Safe landing:
  - Inputs `alt_n`=0000, `vel`=16'h9980 (−20), `thrust`=0005 at a `wen` cycle.
  - Expected: `land`=1 on that edge, `crash`=0, no further `wen` across 100 cycles, `step`=0.
- Speed crash:
  - Inputs `alt_n`=0000, `vel`=16'h9970 (−30), `thrust`=0005.
  - Expected: `crash`=1.
  - Repeat with `vel`=16'h9971 (−29): expect `land`=1 (boundary).
- Thrust crash:
  - Inputs `alt_n`=0000, `vel`=16'h9990, `thrust`=0006.
  - Expected: `crash`=1.
  - Repeat with `thrust`=0005: expect `land`=1.
- Non-touchdown step with `alt_n`=0000 asserted only between `wen` cycles:
  - Expected: no state change, `wen` cadence unaffected.
- Reset mid-operation:
  - Assert `rst_n`=0 asynchronously both while `CRASHED` and at `step`=12.
  - Expected: state=`FLY`, outputs 0 immediately, next `wen` exactly 24 edges after release.
